// File: rtl/regfile_op_sequencer.sv
// Queues register-file operations and issues them one at a time to regfile.
// It holds the indices stable while the result streams back and retires each op on its last beat.
module regfile_op_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16,
  parameter int NREG           = 16,
  localparam int IW            = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [IW-1:0]    instr_src0,
  input  logic [IW-1:0]    instr_src1,
  input  logic [IW-1:0]    instr_dst,
  input  logic             instr_use_src1,
  input  logic             register_file_ready,
  output logic             start_operation,
  output logic [IW-1:0]    source0_register_index,
  output logic [IW-1:0]    source1_register_index,
  output logic [IW-1:0]    destination_register_index,
  output logic             use_source1,
  input  logic             destination_valid,
  input  logic             destination_last,
  output logic             retire_valid,
  output logic [IW-1:0]    retire_dst,
  output logic [CNT_W-1:0] retire_count,
  output logic             busy,
  output logic             error,
  input  logic             clear_error
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_ERROR} state_t;

  typedef struct packed {
    logic [IW-1:0] src0;
    logic [IW-1:0] src1;
    logic [IW-1:0] dst;
    logic          use_src1;
  } op_t;

  state_t            state, state_next;
  op_t               fifo_mem [FIFO_DEPTH];
  op_t               issue_q;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, push, pop, complete, timeout;
  logic [WD_W-1:0]   wd_q;
  logic              retire_valid_q;
  logic [CNT_W-1:0]  retire_count_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = instr_valid && instr_ready;
  assign pop      = (state == ST_IDLE) && !empty && register_file_ready;
  assign complete = ((state == ST_START) || (state == ST_RUN)) &&
                    destination_valid && destination_last;
  assign timeout  = (state == ST_RUN) && !destination_valid &&
                    (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // NOTE: queue storage has no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= '{src0: instr_src0, src1: instr_src1,
                                    dst: instr_dst, use_src1: instr_use_src1};
    end
  end

  // NOTE: every clocked process uses non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      issue_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        issue_q <= fifo_mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q           <= '0;
      retire_valid_q <= 1'b0;
      retire_count_q <= '0;
    end else begin
      if (pop || (((state == ST_START) || (state == ST_RUN)) && destination_valid)) begin
        wd_q <= '0;
      end else if (state == ST_RUN) begin
        wd_q <= wd_q + WD_W'(1);
      end
      retire_valid_q <= complete;
      if (complete) retire_count_q <= retire_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pop) state_next = ST_START;
      ST_START: state_next = complete ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (complete)     state_next = ST_IDLE;
        else if (timeout) state_next = ST_ERROR;
      end
      ST_ERROR: if (clear_error) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    start_operation = 1'b0;
    error           = 1'b0;
    instr_ready     = !full;
    busy            = !empty;
    case (state)
      ST_START: begin
        start_operation = 1'b1;
        busy            = 1'b1;
      end
      ST_RUN:   busy = 1'b1;
      ST_ERROR: begin
        error       = 1'b1;
        instr_ready = 1'b0;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  // The issue register only changes at a pop, which is never earlier than the retire cycle ends.
  assign source0_register_index     = issue_q.src0;
  assign source1_register_index     = issue_q.src1;
  assign destination_register_index = issue_q.dst;
  assign use_source1                = issue_q.use_src1;
  assign retire_valid               = retire_valid_q;
  assign retire_dst                 = issue_q.dst;
  assign retire_count               = retire_count_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed self-checking bench for regfile_op_sequencer (FIFO_DEPTH=4, short watchdog, CNT_W=4).
module tb_regfile_op_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;
  localparam int CW      = 4;
  localparam int IW      = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [IW-1:0] instr_src0 = '0, instr_src1 = '0, instr_dst = '0;
  logic          instr_use_src1 = 1'b0;
  logic          register_file_ready = 1'b1;
  logic          start_operation;
  logic [IW-1:0] source0_register_index, source1_register_index, destination_register_index;
  logic          use_source1;
  logic          destination_valid, destination_last;
  logic          dv_drv = 1'b0, dl_drv = 1'b0, fu_comb = 1'b0;
  logic          retire_valid;
  logic [IW-1:0] retire_dst;
  logic [CW-1:0] retire_count;
  logic          busy, error;
  logic          clear_error = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int retire_seen = 0;
  int start_seen = 0;

  // The fake combinational FU answers every start with a single last beat in the same cycle.
  assign destination_valid = fu_comb ? start_operation : dv_drv;
  assign destination_last  = fu_comb ? start_operation : dl_drv;

  regfile_op_sequencer #(
    .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CW), .NREG(16)
  ) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_src0(instr_src0), .instr_src1(instr_src1), .instr_dst(instr_dst),
    .instr_use_src1(instr_use_src1),
    .register_file_ready(register_file_ready), .start_operation(start_operation),
    .source0_register_index(source0_register_index),
    .source1_register_index(source1_register_index),
    .destination_register_index(destination_register_index),
    .use_source1(use_source1),
    .destination_valid(destination_valid), .destination_last(destination_last),
    .retire_valid(retire_valid), .retire_dst(retire_dst), .retire_count(retire_count),
    .busy(busy), .error(error), .clear_error(clear_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (retire_valid)    retire_seen <= retire_seen + 1;
    if (start_operation) start_seen  <= start_seen + 1;
  end

  // One clock; drops instr_valid once the offered instruction has been taken at this edge.
  task automatic step();
    bit accepted;
    accepted = instr_valid && instr_ready;
    @(posedge clk);
    #1;
    if (accepted) instr_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic push_op(input logic [IW-1:0] s0, s1, d, input logic u);
    int w;
    instr_src0 = s0; instr_src1 = s1; instr_dst = d; instr_use_src1 = u;
    instr_valid = 1'b1;
    w = 0;
    while (instr_valid && w < 100) begin step(); w++; end
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL push_accept dst=%0d: still pending after %0d cycles", d, w);
      instr_valid = 1'b0;
    end
  endtask

  // Waits for a start, checks the issued op, streams nbeats result beats and checks the retire.
  task automatic do_op(input logic [IW-1:0] exp_dst, input logic exp_use, input int nbeats);
    int w;
    w = 0;
    while (!start_operation && w < 64) begin step(); w++; end
    n_cmp++;
    if (start_operation !== 1'b1) begin
      n_bad++;
      $display("FAIL start_wait dst=%0d: start_operation=%b required 1", exp_dst, start_operation);
      return;
    end
    n_cmp++;
    if (destination_register_index !== exp_dst || use_source1 !== exp_use) begin
      n_bad++;
      $display("FAIL issue_order: dst=%0d use=%b required dst=%0d use=%b",
               destination_register_index, use_source1, exp_dst, exp_use);
    end
    for (int b = 0; b < nbeats; b++) begin
      dv_drv = 1'b1;
      dl_drv = (b == nbeats - 1);
      step();
      if (b == 0) begin
        n_cmp++;
        if (start_operation !== 1'b0) begin
          n_bad++;
          $display("FAIL start_one_cycle: start_operation=%b required 0", start_operation);
        end
      end
      if (b < nbeats - 1) begin
        n_cmp++;
        if (destination_register_index !== exp_dst || retire_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL hold_stable: dst=%0d retire_valid=%b required dst=%0d retire_valid=0",
                   destination_register_index, retire_valid, exp_dst);
        end
      end
    end
    dv_drv = 1'b0;
    dl_drv = 1'b0;
    n_cmp++;
    if (retire_valid !== 1'b1 || retire_dst !== exp_dst) begin
      n_bad++;
      $display("FAIL retire: retire_valid=%b retire_dst=%0d required 1/%0d",
               retire_valid, retire_dst, exp_dst);
    end
    step();
    n_cmp++;
    if (retire_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL retire_one_cycle: retire_valid=%b required 0", retire_valid);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (start_operation !== 1'b0 || retire_valid !== 1'b0 || retire_count !== '0 ||
        error !== 1'b0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ctrl: start=%b rv=%b cnt=%0d err=%b busy=%b rdy=%b required 0/0/0/0/0/1",
               start_operation, retire_valid, retire_count, error, busy, instr_ready);
    end
    n_cmp++;
    if (source0_register_index !== '0 || source1_register_index !== '0 ||
        destination_register_index !== '0 || use_source1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idx: %0d/%0d/%0d/%b required 0/0/0/0", source0_register_index,
               source1_register_index, destination_register_index, use_source1);
    end
  endtask

  task automatic test_basic_op();
    push_op(4'd0, 4'd1, 4'd2, 1'b1);
    n_cmp++;
    if (start_operation !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL push_edge: start=%b busy=%b required 0/1", start_operation, busy);
    end
    step();
    n_cmp++;
    if (start_operation !== 1'b1 || source0_register_index !== 4'd0 ||
        source1_register_index !== 4'd1 || use_source1 !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_latency: start=%b src0=%0d src1=%0d use=%b required 1/0/1/1",
               start_operation, source0_register_index, source1_register_index, use_source1);
    end
    do_op(4'd2, 1'b1, 3);
    n_cmp++;
    if (retire_count !== 4'd1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_count: retire_count=%0d busy=%b required 1/0", retire_count, busy);
    end
  endtask

  task automatic test_rf_stall();
    int starts_low;
    apply_reset();
    register_file_ready = 1'b0;
    push_op(4'd3, 4'd4, 4'd5, 1'b0);
    push_op(4'd7, 4'd8, 4'd6, 1'b0);
    starts_low = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (start_operation !== 1'b0) starts_low++;
    end
    n_cmp++;
    if (starts_low != 0 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_no_start: starts=%0d error=%b required 0/0", starts_low, error);
    end
    register_file_ready = 1'b1;
    step();
    n_cmp++;
    if (start_operation !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_resume: start_operation=%b required 1", start_operation);
    end
    do_op(4'd5, 1'b0, 2);
    do_op(4'd6, 1'b0, 1);
    n_cmp++;
    if (retire_count !== 4'd2) begin
      n_bad++;
      $display("FAIL stall_count: retire_count=%0d required 2", retire_count);
    end
  endtask

  task automatic test_back_to_back();
    int starts0;
    apply_reset();
    register_file_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (instr_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL ready_not_full: entry %0d instr_ready=%b required 1", i, instr_ready);
      end
      push_op(IW'(i), IW'(i + 1), IW'(8 + i), i[0]);
    end
    instr_dst = 4'd12; instr_src0 = 4'd4; instr_src1 = 4'd5; instr_use_src1 = 1'b0;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (instr_ready !== 1'b0 || instr_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL full_hold: instr_ready=%b pending=%b required 0/1", instr_ready, instr_valid);
      end
    end
    starts0 = start_seen;
    register_file_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) do_op(IW'(8 + i), i[0], 2);
    step();
    n_cmp++;
    if (retire_count !== 4'd5 || instr_valid !== 1'b0 || busy !== 1'b0 || start_seen - starts0 != 5) begin
      n_bad++;
      $display("FAIL b2b_end: cnt=%0d pending=%b busy=%b starts=%0d required 5/0/0/5",
               retire_count, instr_valid, busy, start_seen - starts0);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    register_file_ready = 1'b0;
    push_op(4'd1, 4'd2, 4'd9, 1'b1);
    push_op(4'd3, 4'd4, 4'd10, 1'b0);
    register_file_ready = 1'b1;
    step();
    n_cmp++;
    if (start_operation !== 1'b1 || destination_register_index !== 4'd9) begin
      n_bad++;
      $display("FAIL wd_start: start=%b dst=%0d required 1/9", start_operation, destination_register_index);
    end
    for (int i = 0; i < TIMEOUT; i++) step();
    n_cmp++;
    if (error !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_early: error=%b required 0", error);
    end
    step();
    n_cmp++;
    if (error !== 1'b1 || instr_ready !== 1'b0 || start_operation !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_fire: err=%b rdy=%b start=%b busy=%b required 1/0/0/1",
               error, instr_ready, start_operation, busy);
    end
    for (int i = 0; i < 3; i++) step();
    clear_error = 1'b1;
    step();
    clear_error = 1'b0;
    n_cmp++;
    if (error !== 1'b0 || retire_valid !== 1'b0 || retire_count !== '0 || instr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_clear: err=%b rv=%b cnt=%0d rdy=%b required 0/0/0/1",
               error, retire_valid, retire_count, instr_ready);
    end
    step();
    n_cmp++;
    if (start_operation !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_next_issue: start_operation=%b required 1", start_operation);
    end
    do_op(4'd10, 1'b0, 2);
    n_cmp++;
    if (retire_count !== 4'd1 || retire_seen == 0) begin
      n_bad++;
      $display("FAIL wd_after: retire_count=%0d required 1", retire_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen0;
    register_file_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_op(IW'(i), IW'(i), IW'(i + 1), 1'b1);
    register_file_ready = 1'b1;
    step();
    dv_drv = 1'b1;
    step();
    dv_drv = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || destination_register_index !== 4'd1) begin
      n_bad++;
      $display("FAIL mid_setup: busy=%b dst=%0d required 1/1", busy, destination_register_index);
    end
    seen0 = retire_seen;
    #2;
    reset = 1'b1;
    dv_drv = 1'b1;
    dl_drv = 1'b1;
    #1;
    n_cmp++;
    if (start_operation !== 1'b0 || retire_count !== '0 || busy !== 1'b0 || error !== 1'b0 ||
        instr_ready !== 1'b1 || destination_register_index !== '0 || use_source1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: start=%b cnt=%0d busy=%b err=%b rdy=%b dst=%0d use=%b required 0/0/0/0/1/0/0",
               start_operation, retire_count, busy, error, instr_ready,
               destination_register_index, use_source1);
    end
    step();
    step();
    dv_drv = 1'b0;
    dl_drv = 1'b0;
    reset = 1'b0;
    step();
    step();
    n_cmp++;
    if (retire_seen != seen0 || busy !== 1'b0 || start_operation !== 1'b0 || retire_count !== '0) begin
      n_bad++;
      $display("FAIL reset_flush: retires=%0d busy=%b start=%b cnt=%0d required 0/0/0/0",
               retire_seen - seen0, busy, start_operation, retire_count);
    end
  endtask

  task automatic test_count_wrap();
    int seen0, w;
    apply_reset();
    fu_comb = 1'b1;
    register_file_ready = 1'b1;
    seen0 = retire_seen;
    for (int i = 0; i < 17; i++) push_op(IW'(i), IW'(i + 1), IW'(i), 1'b1);
    w = 0;
    while ((busy || retire_valid) && w < 200) begin step(); w++; end
    step();
    fu_comb = 1'b0;
    n_cmp++;
    if (retire_count !== 4'd1 || retire_seen - seen0 != 17 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL count_wrap: retire_count=%0d retires=%0d busy=%b required 1/17/0",
               retire_count, retire_seen - seen0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_op();
    test_rf_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_timeout();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
# regfile_op_sequencer

Queues register-file operations (src0, src1, dst, unary/binary) from the instruction front end and issues them one at a time to `regfile`. It drives `start_operation` and the register indices, holds them stable while the functional unit streams the result back, and retires each operation on the last destination coefficient. A watchdog flags a stalled stream. Sits between the instruction decoder and the `regfile` control port.

## Interface
- `FIFO_DEPTH`, 4: instruction queue entries; power of 2, ≥2.
- `TIMEOUT_CYCLES`, 1024: max cycles in an operation without a destination beat before error.
- `CNT_W`, 16: width of the retire counter.
- Register-index width `IW = $clog2(NREG)`; `NREG` comes from `types.svh`.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  queue can accept; `!full && state!=ERROR`.
- `instr_src0`, `instr_src1`, `instr_dst`  in  IW each  register indices.
- `instr_use_src1`  in  1  1 = binary op.
- `register_file_ready`  in  1  from `regfile`; idle and able to start.
- `start_operation`  out  1  one-cycle start pulse to `regfile`.
- `source0_register_index`, `source1_register_index`, `destination_register_index`  out  IW each  driven from the issue register.
- `use_source1`  out  1  driven from the issue register.
- `destination_valid`, `destination_last`  in  1 each  monitored FU→RF result stream.
- `retire_valid`  out  1  one-cycle pulse; operation complete.
- `retire_dst`  out  IW  destination index of the retired op; valid with `retire_valid`.
- `retire_count`  out  CNT_W  total retired ops; wraps modulo 2^CNT_W.
- `busy`  out  1  `state!=IDLE || !empty`.
- `error`  out  1  watchdog fired; sticky until `clear_error`.
- `clear_error`  in  1  leave ERROR.

## Operation
- FIFO:
  - Push on `instr_valid && instr_ready`.
  - Pop only on the IDLE→START transition.
  - No bypass: a pushed entry is visible the cycle after the push edge.
  - Push and pop may happen in the same cycle; occupancy is unchanged.
- FSM states: IDLE, START, RUN, ERROR.
  - IDLE→START when `!empty && register_file_ready`. At that edge, pop the head into the issue register (src0, src1, dst, use_src1).
  - START: `start_operation=1` for exactly this cycle. Next state is RUN, or IDLE if completion is seen in this cycle.
  - RUN→IDLE on completion.
  - RUN→ERROR when the watchdog reaches `TIMEOUT_CYCLES`.
  - ERROR→IDLE when `clear_error=1`. The in-flight op is discarded (not retired); FIFO contents are kept.
- Completion is `destination_valid && destination_last` sampled at a rising edge in START or RUN. It produces:
  - `retire_valid=1` for the next cycle,
  - `retire_dst` = issue-register dst,
  - `retire_count` incremented.
- Outside START/RUN, `destination_*` is ignored and never retires an op.
- Index outputs and `use_source1` change only at pop edges. They hold from START through the completion cycle and keep their last value in IDLE and ERROR.
- Watchdog counter:
  - Cleared on entry to START and on every `destination_valid` beat.
  - Increments each RUN cycle without a beat.
  - Error fires when the count reaches `TIMEOUT_CYCLES`.
- `error` is set on entry to ERROR and cleared by `clear_error`.
- In ERROR, `start_operation=0` and `instr_ready=0`.

## Timing
- Reset values:
  - State IDLE, FIFO empty.
  - `start_operation=0`, `retire_valid=0`, `retire_count=0`, `error=0`, `busy=0`.
  - Index outputs and `use_source1` = 0.
  - `instr_ready=1`.
- Reset asserted mid-operation aborts immediately. The op is not retired and the queue is flushed.
- Outputs are decoded from registered state only; no input→output combinational path.
- Issue latency with an empty queue and ready RF:
  - push at edge N;
  - IDLE→START at edge N+1;
  - `start_operation` high between edges N+1 and N+2.
- Completion sampled at edge M gives `retire_valid` high between M and M+1. The next start is possible at edge M+1 at the earliest, if `register_file_ready` is high.
- Back-to-back ops: minimum 1 IDLE cycle between an op's completion and the next START.
- `register_file_ready` low in IDLE stalls issue indefinitely; this is not an error.
- `clear_error` outside ERROR has no effect.

## Test plan
- Reset, then push binary (0,1→2). Required:
  - `start_operation` pulses exactly 1 cycle, 1 cycle after the push edge;
  - indices 0/1/2 and `use_source1=1` stay stable until `destination_last`;
  - `retire_valid` pulses once with `retire_dst=2` and `retire_count=1`.
- Push 4 ops back-to-back (FIFO_DEPTH=4). Required:
  - `instr_ready` drops only while the queue is full;
  - the 5th push is held;
  - all ops issue in order, one start per op;
  - `retire_count=5` at the end.
- Hold `register_file_ready=0` with 2 ops queued. Required: no start while low; issue resumes one cycle after it rises.
- Stream with no `destination_valid` for `TIMEOUT_CYCLES`. Required:
  - `error=1` and `instr_ready=0`;
  - `clear_error` returns to IDLE with no retire for the aborted op;
  - the queued op then issues.
- Assert `reset` mid-RUN with 3 ops queued. Required: outputs return to reset values immediately and no retire occurs.
- Push 2^CNT_W+1 ops (CNT_W=4 build) through a fake combinational FU. Required: `retire_count` wraps to 1.
